icache_req_rr_arb: RTL and testbench

//  Round-robin arbiter with burst lock that shares one icache request channel among REQ_NUM requesters.

---
 rtl/icache_arb_pkg.sv | 17 +
 rtl/cmn_rr_pick_onehot.sv | 44 ++++
 rtl/icache_req_rr_arb.sv | 134 +++++++++++++
 tb/tb_icache_req_rr_arb.sv | 370 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/icache_arb_pkg.sv
// Shared definitions for the icache request arbiter.
//   ARB_MAX_REQ  : largest requester count the id type can encode
//   arb_id_t     : wide-enough requester index type
//   arb_next_ptr : round-robin successor with wrap at n-1 -> 0
package icache_arb_pkg;

  localparam int unsigned ARB_MAX_REQ = 16;
  localparam int unsigned ARB_ID_W    = $clog2(ARB_MAX_REQ);

  typedef logic [ARB_ID_W-1:0] arb_id_t;

  function automatic arb_id_t arb_next_ptr(arb_id_t id, int unsigned n);
    if (32'(id) == n - 1) return '0;
    return id + 1'b1;
  endfunction

endpackage

// File: rtl/cmn_rr_pick_onehot.sv
// Combinational rotating-priority picker.
//   req     in  [N]     request vector
//   ptr     in  [ID_W]  index holding highest priority
//   gnt     out [N]     onehot grant (zero when no request)
//   gnt_id  out [ID_W]  encoded index of the granted request
//   gnt_vld out 1       any request present
module cmn_rr_pick_onehot
  import icache_arb_pkg::*;
#(
  parameter int unsigned N    = 4,
  parameter int unsigned ID_W = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] ptr,
  output logic [N-1:0]    gnt,
  output logic [ID_W-1:0] gnt_id,
  output logic            gnt_vld
);

  logic [N-1:0] hi_mask;
  logic [N-1:0] req_hi;
  logic [N-1:0] gnt_hi;
  logic [N-1:0] gnt_all;

  // Requests at or above ptr get first chance; if none, the plain
  // lowest-index request wins, which is the wrapped-around search.
  for (genvar gi = 0; gi < N; gi++) begin : g_mask
    assign hi_mask[gi] = (ID_W'(gi) >= ptr);
  end

  assign req_hi  = req & hi_mask;
  assign gnt_hi  = req_hi & (~req_hi + N'(1));
  assign gnt_all = req & (~req + N'(1));
  assign gnt     = (|req_hi) ? gnt_hi : gnt_all;
  assign gnt_vld = |req;

  always_comb begin
    gnt_id = '0;
    for (int i = 0; i < N; i++) begin
      if (gnt[i]) gnt_id = ID_W'(i);
    end
  end

endmodule

// File: rtl/icache_req_rr_arb.sv
// Round-robin arbiter with burst lock feeding one registered icache
// request channel.
//   clk, rst                 clock, synchronous active-high reset
//   a_req_vld/rdy/last/pld   per-requester request channels (unpacked)
//   out_req_vld/rdy          registered downstream handshake
//   out_req_pld/id/last      registered payload, source index, last flag
// A beat with last=0 locks the channel to its source until a last=1
// beat; the priority pointer moves only on last beats.
module icache_req_rr_arb
  import icache_arb_pkg::*;
#(
  parameter int unsigned REQ_NUM  = 4,
  parameter type         PLD_TYPE = logic,
  parameter int unsigned ID_W     = $clog2(REQ_NUM)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            a_req_vld  [REQ_NUM],
  output logic            a_req_rdy  [REQ_NUM],
  input  logic            a_req_last [REQ_NUM],
  input  PLD_TYPE         a_req_pld  [REQ_NUM],
  output logic            out_req_vld,
  input  logic            out_req_rdy,
  output PLD_TYPE         out_req_pld,
  output logic [ID_W-1:0] out_req_id,
  output logic            out_req_last
);

  logic [REQ_NUM-1:0] vld_vec;
  logic [REQ_NUM-1:0] last_vec;
  logic [REQ_NUM-1:0] lock_mask;
  logic [REQ_NUM-1:0] pick_req;
  logic [REQ_NUM-1:0] gnt;
  logic [REQ_NUM-1:0] rdy_vec;
  logic [ID_W-1:0]    pick_ptr;
  logic [ID_W-1:0]    gnt_id;
  logic               gnt_vld;
  logic               stage_free;
  logic               grant_en;
  logic               hs;
  logic               beat_last;
  PLD_TYPE            pld_mux;

  logic [ID_W-1:0]    ptr_reg;
  logic               lock_reg;
  logic [ID_W-1:0]    lock_id_reg;
  logic               out_vld_reg;
  logic [ID_W-1:0]    out_id_reg;
  logic               out_last_reg;
  PLD_TYPE            out_pld_reg;

  for (genvar gi = 0; gi < REQ_NUM; gi++) begin : g_req
    assign vld_vec[gi]   = a_req_vld[gi];
    assign last_vec[gi]  = a_req_last[gi];
    assign lock_mask[gi] = (ID_W'(gi) == lock_id_reg);
    assign rdy_vec[gi]   = gnt[gi] & grant_en;
    assign a_req_rdy[gi] = rdy_vec[gi];
  end

  assign stage_free = !out_vld_reg || out_req_rdy;
  // Reset gating keeps every ready low for the whole reset cycle.
  assign grant_en   = stage_free && !rst;

  // While locked, the picker only ever sees the lock owner, so other
  // requesters stay off even when the owner pauses its burst.
  assign pick_req = lock_reg ? (vld_vec & lock_mask) : vld_vec;
  assign pick_ptr = lock_reg ? lock_id_reg : ptr_reg;

  cmn_rr_pick_onehot #(
    .N    (REQ_NUM),
    .ID_W (ID_W)
  ) u_pick (
    .req     (pick_req),
    .ptr     (pick_ptr),
    .gnt     (gnt),
    .gnt_id  (gnt_id),
    .gnt_vld (gnt_vld)
  );

  assign hs        = gnt_vld && grant_en;
  assign beat_last = |(gnt & last_vec);

  always_comb begin
    pld_mux = a_req_pld[0];
    for (int i = 1; i < REQ_NUM; i++) begin
      if (gnt[i]) pld_mux = a_req_pld[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_vld_reg  <= 1'b0;
      out_id_reg   <= '0;
      out_last_reg <= 1'b0;
      ptr_reg      <= '0;
      lock_reg     <= 1'b0;
      lock_id_reg  <= '0;
    end else if (hs) begin
      // A load also covers a simultaneous drain: no bubble.
      out_vld_reg  <= 1'b1;
      out_id_reg   <= gnt_id;
      out_last_reg <= beat_last;
      if (beat_last) begin
        lock_reg <= 1'b0;
        ptr_reg  <= ID_W'(arb_next_ptr(arb_id_t'(gnt_id), REQ_NUM));
      end else begin
        lock_reg    <= 1'b1;
        lock_id_reg <= gnt_id;
      end
    end else if (out_req_rdy) begin
      out_vld_reg <= 1'b0;
    end
  end

  // Payload needs no reset; it is qualified by out_vld_reg.
  always_ff @(posedge clk) begin
    if (hs) out_pld_reg <= pld_mux;
  end

  assign out_req_vld  = out_vld_reg;
  assign out_req_id   = out_id_reg;
  assign out_req_last = out_last_reg;
  assign out_req_pld  = out_pld_reg;

`ifndef SYNTHESIS
  a_rdy_onehot0 : assert property (@(posedge clk) $onehot0(rdy_vec));
  a_lock_only : assert property (@(posedge clk) disable iff (rst)
    lock_reg |-> ((rdy_vec & ~lock_mask) == '0));
  a_out_stable : assert property (@(posedge clk) disable iff (rst)
    (out_vld_reg && !out_req_rdy) |=> (out_vld_reg && $stable(out_pld_reg)
      && $stable(out_id_reg) && $stable(out_last_reg)));
`endif

endmodule

// File: tb/tb_icache_req_rr_arb.sv
module tb_icache_req_rr_arb;

  localparam int N = 4;
  typedef logic [7:0] pld_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       a_req_vld  [N];
  logic       a_req_rdy  [N];
  logic       a_req_last [N];
  pld_t       a_req_pld  [N];
  logic       out_req_vld;
  logic       out_req_rdy;
  pld_t       out_req_pld;
  logic [1:0] out_req_id;
  logic       out_req_last;
  logic [3:0] rdy_vec;

  int n_checks = 0;
  int n_fail   = 0;

  icache_req_rr_arb #(
    .REQ_NUM  (N),
    .PLD_TYPE (pld_t),
    .ID_W     (2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .a_req_vld    (a_req_vld),
    .a_req_rdy    (a_req_rdy),
    .a_req_last   (a_req_last),
    .a_req_pld    (a_req_pld),
    .out_req_vld  (out_req_vld),
    .out_req_rdy  (out_req_rdy),
    .out_req_pld  (out_req_pld),
    .out_req_id   (out_req_id),
    .out_req_last (out_req_last)
  );

  always #5 clk = ~clk;

  always_comb begin
    rdy_vec = '0;
    for (int i = 0; i < N; i++) rdy_vec[i] = a_req_rdy[i];
  end

  always @(posedge clk) begin
    if (!rst && out_req_vld && out_req_rdy)
      $display("txn: id=%0d pld=%02h last=%0b", out_req_id, out_req_pld, out_req_last);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs;
    for (int i = 0; i < N; i++) begin
      a_req_vld[i]  = 1'b0;
      a_req_last[i] = 1'b1;
      a_req_pld[i]  = '0;
    end
  endtask

  task automatic do_reset;
    rst = 1'b1;
    out_req_rdy = 1'b1;
    clear_inputs();
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    out_req_rdy = 1'b1;
    for (int i = 0; i < N; i++) begin
      a_req_vld[i] = 1'b1; a_req_last[i] = 1'b1; a_req_pld[i] = pld_t'(8'hE0 + i);
    end
    tick();
    tick();
    n_checks++;
    if (out_req_vld !== 1'b0 || out_req_id !== 2'd0 || out_req_last !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_out: got vld=%b id=%0d last=%b, required 0/0/0", out_req_vld, out_req_id, out_req_last);
    end
    n_checks++;
    if (rdy_vec !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_rdy: got %b required 0000", rdy_vec);
    end
    n_checks++;
    if (dut.ptr_reg !== 2'd0 || dut.lock_reg !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: got ptr=%0d lock=%b required 0/0", dut.ptr_reg, dut.lock_reg);
    end
    clear_inputs();
  endtask

  task automatic test_round_robin;
    int exp_seq [5];
    exp_seq = '{0, 1, 2, 3, 0};
    do_reset();
    for (int i = 0; i < N; i++) begin
      a_req_vld[i] = 1'b1; a_req_last[i] = 1'b1; a_req_pld[i] = pld_t'(8'hA0 + i);
    end
    #1;
    for (int k = 0; k < 5; k++) begin
      n_checks++;
      if (rdy_vec !== 4'(1 << exp_seq[k])) begin
        n_fail++;
        $display("FAIL rr_rdy%0d: got %b required %b", k, rdy_vec, 4'(1 << exp_seq[k]));
      end
      tick();
      n_checks++;
      if (out_req_vld !== 1'b1 || out_req_id !== 2'(exp_seq[k]) || out_req_pld !== pld_t'(8'hA0 + exp_seq[k])) begin
        n_fail++;
        $display("FAIL rr_out%0d: got vld=%b id=%0d pld=%02h required 1/%0d/%02h",
                 k, out_req_vld, out_req_id, out_req_pld, exp_seq[k], 8'hA0 + exp_seq[k]);
      end
    end
    clear_inputs();
    tick();
    n_checks++;
    if (out_req_vld !== 1'b0 || dut.ptr_reg !== 2'd1 || dut.lock_reg !== 1'b0) begin
      n_fail++;
      $display("FAIL rr_idle: got vld=%b ptr=%0d lock=%b required 0/1/0", out_req_vld, dut.ptr_reg, dut.lock_reg);
    end
  endtask

  task automatic test_burst;
    logic [1:0] exp_id  [5];
    pld_t       exp_pld [5];
    logic       exp_lst [5];
    exp_id  = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd2};
    exp_pld = '{8'h01, 8'h02, 8'h03, 8'h11, 8'h21};
    exp_lst = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    do_reset();
    a_req_vld[1] = 1'b1; a_req_pld[1] = 8'h11;
    a_req_vld[2] = 1'b1; a_req_pld[2] = 8'h21;
    for (int k = 0; k < 5; k++) begin
      if (k < 3) begin
        a_req_vld[0] = 1'b1; a_req_pld[0] = exp_pld[k]; a_req_last[0] = exp_lst[k];
      end else begin
        a_req_vld[0] = 1'b0;
      end
      if (k == 4) a_req_vld[1] = 1'b0;
      #1;
      n_checks++;
      if (rdy_vec !== 4'(1 << exp_id[k])) begin
        n_fail++;
        $display("FAIL burst_rdy%0d: got %b required %b", k, rdy_vec, 4'(1 << exp_id[k]));
      end
      tick();
      n_checks++;
      if (out_req_vld !== 1'b1 || out_req_id !== exp_id[k] || out_req_pld !== exp_pld[k] || out_req_last !== exp_lst[k]) begin
        n_fail++;
        $display("FAIL burst_out%0d: got id=%0d pld=%02h last=%b required %0d/%02h/%b",
                 k, out_req_id, out_req_pld, out_req_last, exp_id[k], exp_pld[k], exp_lst[k]);
      end
      if (k == 2) begin
        n_checks++;
        if (dut.ptr_reg !== 2'd1 || dut.lock_reg !== 1'b0) begin
          n_fail++;
          $display("FAIL burst_ptr: got ptr=%0d lock=%b required 1/0", dut.ptr_reg, dut.lock_reg);
        end
      end
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_lock_hold;
    do_reset();
    a_req_vld[2] = 1'b1; a_req_last[2] = 1'b0; a_req_pld[2] = 8'h21;
    a_req_vld[3] = 1'b1; a_req_last[3] = 1'b1; a_req_pld[3] = 8'h31;
    #1;
    n_checks++;
    if (rdy_vec !== 4'b0100) begin
      n_fail++;
      $display("FAIL lock_first: got %b required 0100", rdy_vec);
    end
    tick();
    a_req_vld[2] = 1'b0;
    for (int k = 0; k < 2; k++) begin
      #1;
      n_checks++;
      if (rdy_vec !== 4'b0000) begin
        n_fail++;
        $display("FAIL lock_hold%0d: got %b required 0000", k, rdy_vec);
      end
      tick();
    end
    n_checks++;
    if (out_req_vld !== 1'b0) begin
      n_fail++;
      $display("FAIL lock_drain: got vld=%b required 0", out_req_vld);
    end
    a_req_vld[2] = 1'b1; a_req_last[2] = 1'b1; a_req_pld[2] = 8'h22;
    #1;
    n_checks++;
    if (rdy_vec !== 4'b0100) begin
      n_fail++;
      $display("FAIL lock_resume: got %b required 0100", rdy_vec);
    end
    tick();
    n_checks++;
    if (out_req_id !== 2'd2 || out_req_pld !== 8'h22 || out_req_last !== 1'b1) begin
      n_fail++;
      $display("FAIL lock_resume_out: got id=%0d pld=%02h last=%b required 2/22/1", out_req_id, out_req_pld, out_req_last);
    end
    a_req_vld[2] = 1'b0;
    #1;
    n_checks++;
    if (rdy_vec !== 4'b1000) begin
      n_fail++;
      $display("FAIL lock_next: got %b required 1000", rdy_vec);
    end
    tick();
    n_checks++;
    if (out_req_id !== 2'd3 || out_req_pld !== 8'h31) begin
      n_fail++;
      $display("FAIL lock_next_out: got id=%0d pld=%02h required 3/31", out_req_id, out_req_pld);
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_stall;
    do_reset();
    out_req_rdy = 1'b0;
    a_req_vld[0] = 1'b1; a_req_pld[0] = 8'h05;
    tick();
    a_req_pld[0] = 8'h06;
    a_req_vld[1] = 1'b1; a_req_pld[1] = 8'h15;
    for (int k = 0; k < 5; k++) begin
      #1;
      n_checks++;
      if (rdy_vec !== 4'b0000 || out_req_vld !== 1'b1 || out_req_id !== 2'd0 || out_req_pld !== 8'h05) begin
        n_fail++;
        $display("FAIL stall%0d: got rdy=%b vld=%b id=%0d pld=%02h required 0000/1/0/05",
                 k, rdy_vec, out_req_vld, out_req_id, out_req_pld);
      end
      tick();
    end
    out_req_rdy = 1'b1;
    #1;
    n_checks++;
    if (rdy_vec !== 4'b0010) begin
      n_fail++;
      $display("FAIL stall_release_rdy: got %b required 0010", rdy_vec);
    end
    tick();
    n_checks++;
    if (out_req_vld !== 1'b1 || out_req_id !== 2'd1 || out_req_pld !== 8'h15) begin
      n_fail++;
      $display("FAIL stall_reload: got vld=%b id=%0d pld=%02h required 1/1/15", out_req_vld, out_req_id, out_req_pld);
    end
    a_req_vld[1] = 1'b0;
    tick();
    n_checks++;
    if (out_req_vld !== 1'b1 || out_req_id !== 2'd0 || out_req_pld !== 8'h06) begin
      n_fail++;
      $display("FAIL stall_next: got vld=%b id=%0d pld=%02h required 1/0/06", out_req_vld, out_req_id, out_req_pld);
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_wrap;
    do_reset();
    a_req_vld[2] = 1'b1; a_req_pld[2] = 8'h2A;
    tick();
    n_checks++;
    if (dut.ptr_reg !== 2'd3) begin
      n_fail++;
      $display("FAIL wrap_ptr3: got %0d required 3", dut.ptr_reg);
    end
    a_req_vld[2] = 1'b0;
    a_req_vld[3] = 1'b1; a_req_pld[3] = 8'h3A;
    tick();
    n_checks++;
    if (out_req_id !== 2'd3 || dut.ptr_reg !== 2'd0) begin
      n_fail++;
      $display("FAIL wrap_ptr0: got id=%0d ptr=%0d required 3/0", out_req_id, dut.ptr_reg);
    end
    a_req_vld[0] = 1'b1; a_req_pld[0] = 8'h0A;
    a_req_pld[3] = 8'h3B;
    #1;
    n_checks++;
    if (rdy_vec !== 4'b0001) begin
      n_fail++;
      $display("FAIL wrap_pick: got %b required 0001", rdy_vec);
    end
    tick();
    n_checks++;
    if (out_req_id !== 2'd0 || out_req_pld !== 8'h0A) begin
      n_fail++;
      $display("FAIL wrap_out: got id=%0d pld=%02h required 0/0A", out_req_id, out_req_pld);
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_reset_mid_burst;
    do_reset();
    a_req_vld[1] = 1'b1; a_req_last[1] = 1'b0; a_req_pld[1] = 8'h41;
    tick();
    n_checks++;
    if (dut.lock_reg !== 1'b1 || out_req_id !== 2'd1) begin
      n_fail++;
      $display("FAIL rstb_lock: got lock=%b id=%0d required 1/1", dut.lock_reg, out_req_id);
    end
    rst = 1'b1;
    a_req_pld[1] = 8'h42;
    #1;
    n_checks++;
    if (rdy_vec !== 4'b0000) begin
      n_fail++;
      $display("FAIL rstb_rdy: got %b required 0000", rdy_vec);
    end
    tick();
    n_checks++;
    if (out_req_vld !== 1'b0 || dut.lock_reg !== 1'b0 || dut.ptr_reg !== 2'd0) begin
      n_fail++;
      $display("FAIL rstb_state: got vld=%b lock=%b ptr=%0d required 0/0/0", out_req_vld, dut.lock_reg, dut.ptr_reg);
    end
    rst = 1'b0;
    a_req_vld[0] = 1'b1; a_req_last[0] = 1'b1; a_req_pld[0] = 8'h50;
    a_req_last[1] = 1'b1; a_req_pld[1] = 8'h41;
    #1;
    n_checks++;
    if (rdy_vec !== 4'b0001) begin
      n_fail++;
      $display("FAIL rstb_first: got %b required 0001", rdy_vec);
    end
    tick();
    a_req_vld[0] = 1'b0;
    #1;
    n_checks++;
    if (out_req_id !== 2'd0 || out_req_pld !== 8'h50 || rdy_vec !== 4'b0010) begin
      n_fail++;
      $display("FAIL rstb_second: got id=%0d pld=%02h rdy=%b required 0/50/0010", out_req_id, out_req_pld, rdy_vec);
    end
    tick();
    clear_inputs();
    tick();
  endtask

  initial begin
    out_req_rdy = 1'b1;
    clear_inputs();
    test_reset();
    test_round_robin();
    test_burst();
    test_lock_hold();
    test_stall();
    test_wrap();
    test_reset_mid_burst();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
